// File: rtl/fp_alu_rsp.sv
// fp_alu_rsp: registered request/response wrapper around a combinational
// single-precision ALU. Requests land in an operand register (S1). The ALU
// result is pushed into a 2-entry in-order response FIFO.
// Optional build macro FP_ALU_RSP_STICKY_EN adds sticky accumulation of the
// {exception, overflow, underflow} flags, cleared by flag_clr.
//
// ALU opcodes: 4'b1010 = add, 4'b1011 = sub. Rounding is toward zero.
// Subnormal inputs are flushed to zero. Any other opcode yields 0 with no flags.

module fp_alu (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  op,
    output logic [31:0] result,
    output logic        exception,
    output logic        overflow,
    output logic        underflow
);
    localparam logic [3:0] OP_ADD = 4'b1010;
    localparam logic [3:0] OP_SUB = 4'b1011;

    logic              sa, sb, a_big, s_big, eff_sub;
    logic [7:0]        ea, eb, e_big, e_small, d;
    logic [23:0]       ma, mb, m_big, m_small;
    logic [22:0]       mant;
    logic [4:0]        dsat, lz;
    logic [53:0]       wide;
    logic [26:0]       aligned, norm;
    logic [27:0]       big_x, sum;
    logic signed [9:0] exp_n;

    // Unpack, align the smaller magnitude (guard/round/sticky kept), add or
    // subtract the magnitudes, then normalise.
    always_comb begin
        sa      = a[31];
        sb      = b[31] ^ (op == OP_SUB);
        ea      = a[30:23];
        eb      = b[30:23];
        ma      = (ea != 8'd0) ? {1'b1, a[22:0]} : 24'd0;
        mb      = (eb != 8'd0) ? {1'b1, b[22:0]} : 24'd0;
        a_big   = (a[30:0] >= b[30:0]);
        s_big   = a_big ? sa : sb;
        e_big   = a_big ? ea : eb;
        e_small = a_big ? eb : ea;
        m_big   = a_big ? ma : mb;
        m_small = a_big ? mb : ma;
        eff_sub = sa ^ sb;
        d       = e_big - e_small;
        dsat    = (d > 8'd31) ? 5'd31 : d[4:0];
        wide    = {m_small, 30'd0} >> dsat;
        aligned = {wide[53:28], |wide[27:0]};
        big_x   = {1'b0, m_big, 3'b000};
        sum     = eff_sub ? (big_x - {1'b0, aligned}) : (big_x + {1'b0, aligned});
        lz      = 5'd0;
        for (int i = 0; i < 27; i++)
            if (sum[i]) lz = 5'(26 - i);
        norm    = sum[26:0] << lz;
        if (sum[27]) begin
            mant  = 23'(sum >> 4);
            exp_n = $signed({2'b00, e_big}) + 10'sd1;
        end else begin
            mant  = 23'(norm >> 3);
            exp_n = $signed({2'b00, e_big}) - $signed({5'd0, lz});
        end
    end

    // Special cases, range checks and opcode select.
    always_comb begin
        result    = 32'd0;
        exception = 1'b0;
        overflow  = 1'b0;
        underflow = 1'b0;
        if (op == OP_ADD || op == OP_SUB) begin
            if (ea == 8'hFF || eb == 8'hFF) begin
                result    = 32'h7FC0_0000;
                exception = 1'b1;
            end else if (sum == 28'd0) begin
                result = 32'd0;
            end else if (exp_n >= 10'sd255) begin
                result   = {s_big, 8'hFF, 23'd0};
                overflow = 1'b1;
            end else if (exp_n <= 10'sd0) begin
                result    = {s_big, 31'd0};
                underflow = 1'b1;
            end else begin
                result = {s_big, exp_n[7:0], mant};
            end
        end
    end
endmodule

module fp_alu_rsp #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [31:0]      req_a,
    input  logic [31:0]      req_b,
    input  logic [3:0]       req_op,
    input  logic [TAG_W-1:0] req_tag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [31:0]      rsp_result,
    output logic             rsp_exception,
    output logic             rsp_overflow,
    output logic             rsp_underflow,
    output logic [TAG_W-1:0] rsp_tag,
    output logic             busy,
    input  logic             flag_clr,
    output logic [2:0]       sticky_flags
);
    typedef struct packed {
        logic [31:0]      result;
        logic             exc;
        logic             ovf;
        logic             unf;
        logic [TAG_W-1:0] tag;
    } rsp_t;

    logic             s1_valid;
    logic [31:0]      s1_a, s1_b;
    logic [3:0]       s1_op;
    logic [TAG_W-1:0] s1_tag;
    logic [31:0]      alu_result;
    logic             alu_exc, alu_ovf, alu_unf;
    rsp_t             fifo_mem [2];
    logic             wptr, rptr;
    logic [1:0]       count;
    logic             push, pop, s1_adv;

    fp_alu u_alu (
        .a         (s1_a),
        .b         (s1_b),
        .op        (s1_op),
        .result    (alu_result),
        .exception (alu_exc),
        .overflow  (alu_ovf),
        .underflow (alu_unf)
    );

    assign pop       = rsp_valid & rsp_ready;
    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign s1_adv    = s1_valid & ((count != 2'd2) | pop);
    assign push      = s1_adv;
    assign req_ready = rst_n & (~s1_valid | s1_adv);
    assign rsp_valid = (count != 2'd0);
    assign busy      = s1_valid | (count != 2'd0);

    assign rsp_result    = fifo_mem[rptr].result;
    assign rsp_exception = fifo_mem[rptr].exc;
    assign rsp_overflow  = fifo_mem[rptr].ovf;
    assign rsp_underflow = fifo_mem[rptr].unf;
    assign rsp_tag       = fifo_mem[rptr].tag;

    // Operand register: loads on handshake, empties when it advances.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_a     <= 32'd0;
            s1_b     <= 32'd0;
            s1_op    <= 4'd0;
            s1_tag   <= '0;
        end else if (req_valid && req_ready) begin
            s1_valid <= 1'b1;
            s1_a     <= req_a;
            s1_b     <= req_b;
            s1_op    <= req_op;
            s1_tag   <= req_tag;
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    // Two-entry response FIFO; storage is cleared so outputs read 0 in reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fifo_mem[0] <= '0;
            fifo_mem[1] <= '0;
            wptr        <= 1'b0;
            rptr        <= 1'b0;
            count       <= 2'd0;
        end else begin
            if (push) begin
                fifo_mem[wptr] <= '{alu_result, alu_exc, alu_ovf, alu_unf, s1_tag};
                wptr           <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            if (push && !pop)      count <= count + 2'd1;
            else if (!push && pop) count <= count - 2'd1;
        end
    end

`ifdef FP_ALU_RSP_STICKY_EN
    // Sticky flags: a write in the clear cycle still sets its bits.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sticky_flags <= 3'b000;
        else        sticky_flags <= (flag_clr ? 3'b000 : sticky_flags)
                                    | (push ? {alu_exc, alu_ovf, alu_unf} : 3'b000);
    end
`else
    logic unused_flag_clr;
    assign unused_flag_clr = flag_clr;
    assign sticky_flags    = 3'b000;
`endif
endmodule

// File: tb/tb_fp_alu_rsp.sv
// Bench for fp_alu_rsp: table of hand-computed ALU vectors fed through a
// scoreboard, plus sequences for latency, backpressure, full-buffer
// push/pop, asynchronous reset and sticky flags.
module tb_fp_alu_rsp;
    localparam int TAG_W = 4;
    localparam int NV    = 11;

    logic             clk, rst_n, req_valid, req_ready, rsp_valid, rsp_ready;
    logic [31:0]      req_a, req_b, rsp_result;
    logic [3:0]       req_op;
    logic [TAG_W-1:0] req_tag, rsp_tag;
    logic             rsp_exception, rsp_overflow, rsp_underflow, busy, flag_clr;
    logic [2:0]       sticky_flags;

    fp_alu_rsp #(.TAG_W(TAG_W)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_tag(req_tag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_exception(rsp_exception), .rsp_overflow(rsp_overflow),
        .rsp_underflow(rsp_underflow), .rsp_tag(rsp_tag), .busy(busy),
        .flag_clr(flag_clr), .sticky_flags(sticky_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a, b;
        logic [3:0]  op;
        logic [31:0] res;
        logic [2:0]  flg;   // {exc, ovf, unf}
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  flg;
        logic [3:0]  tag;
    } exp_t;

    vec_t        vt [NV];
    exp_t        sbq [$];
    exp_t        e_pop, e_push;
    logic [31:0] cur_res;
    logic [2:0]  cur_flg;
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    task automatic set_req(input int idx, input int tag);
        req_valid = 1'b1;
        req_a     = vt[idx].a;
        req_b     = vt[idx].b;
        req_op    = vt[idx].op;
        req_tag   = 4'(tag);
        cur_res   = vt[idx].res;
        cur_flg   = vt[idx].flg;
    endtask

    // Offer n requests (vectors idx0.., tags tag0..); stops after maxcyc cycles
    // leaving the pending request asserted if not all were taken.
    task automatic issue(input int n, input int idx0, input int tag0, input int maxcyc,
                         output int acc);
        int  k;
        logic hs;
        acc = 0;
        k   = 0;
        set_req(idx0 % NV, tag0);
        while (acc < n && k < maxcyc) begin
            @(negedge clk);
            hs = req_valid && req_ready;
            @(posedge clk);
            #1;
            k++;
            if (hs) begin
                acc++;
                if (acc < n) set_req((idx0 + acc) % NV, tag0 + acc);
                else         req_valid = 1'b0;
            end
        end
    endtask

    task automatic drain();
        int k;
        k = 0;
        rsp_ready = 1'b1;
        while ((sbq.size() != 0 || rsp_valid) && k < 30) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_outstanding", sbq.size(), 0);
    endtask

    // Scoreboard: push on request handshake, pop and compare on response.
    always @(negedge clk) begin
        if (rst_n) begin
            if (req_valid && req_ready) begin
                e_push.res = cur_res;
                e_push.flg = cur_flg;
                e_push.tag = req_tag;
                sbq.push_back(e_push);
            end
            if (rsp_valid && rsp_ready) begin
                n_tests++;
                if (sbq.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected: tag %0d result %h, expected no response",
                             rsp_tag, rsp_result);
                end else begin
                    e_pop = sbq.pop_front();
                    if (rsp_result !== e_pop.res || rsp_tag !== e_pop.tag ||
                        {rsp_exception, rsp_overflow, rsp_underflow} !== e_pop.flg) begin
                        n_fail++;
                        $display("FAIL rsp: got tag %0d res %h flg %b, expected tag %0d res %h flg %b",
                                 rsp_tag, rsp_result, {rsp_exception, rsp_overflow, rsp_underflow},
                                 e_pop.tag, e_pop.res, e_pop.flg);
                    end
                end
            end
        end
    end

    initial begin
        int acc;
        vt[0]  = '{32'h4201_51EC, 32'h4242_147B, 4'b1010, 32'h42A1_B333, 3'b000};
        vt[1]  = '{32'h3F80_0000, 32'h3F80_0000, 4'b1010, 32'h4000_0000, 3'b000};
        vt[2]  = '{32'h4040_0000, 32'h3F80_0000, 4'b1011, 32'h4000_0000, 3'b000};
        vt[3]  = '{32'h3F80_0000, 32'hBF80_0000, 4'b1010, 32'h0000_0000, 3'b000};
        vt[4]  = '{32'h7F7F_FFFF, 32'h7F7F_FFFF, 4'b1010, 32'h7F80_0000, 3'b010};
        vt[5]  = '{32'h7F80_0000, 32'h3F80_0000, 4'b1010, 32'h7FC0_0000, 3'b100};
        vt[6]  = '{32'h0080_0001, 32'h0080_0000, 4'b1011, 32'h0000_0000, 3'b001};
        vt[7]  = '{32'h3F80_0000, 32'h3380_0000, 4'b1010, 32'h3F80_0000, 3'b000};
        vt[8]  = '{32'h3FC0_0000, 32'h4010_0000, 4'b1010, 32'h4070_0000, 3'b000};
        vt[9]  = '{32'hC000_0000, 32'h3F00_0000, 4'b1010, 32'hBFC0_0000, 3'b000};
        vt[10] = '{32'h3F80_0000, 32'h3F80_0000, 4'b0000, 32'h0000_0000, 3'b000};

        rst_n = 1'b0; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_tag = '0;
        rsp_ready = 1'b1; flag_clr = 1'b0; cur_res = '0; cur_flg = '0;

        // Reset state
        #12;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_sticky", sticky_flags, 0);
        chk("rst_rsp_result", rsp_result, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single op latency
        set_req(0, 3);
        @(negedge clk);
        chk("single_req_ready", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        chk("single_valid_k", rsp_valid, 0);
        chk("single_busy", busy, 1);
        @(posedge clk);
        #1;
        chk("single_valid_k1", rsp_valid, 1);
        chk("single_result", rsp_result, 32'h42A1_B333);
        chk("single_tag", rsp_tag, 3);
        drain();

        // Back-to-back stream over the whole vector table
        for (int i = 0; i < NV; i++) begin
            set_req(i, i);
            @(negedge clk);
            chk("stream_ready", req_ready, 1);
            if (i >= 2) chk("stream_valid", rsp_valid, 1);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        drain();

        // Backpressure: only 3 of 4 accepted, 4th goes on the first pop cycle
        rsp_ready = 1'b0;
        issue(4, 0, 0, 6, acc);
        chk("bp_accepted", acc, 3);
        @(negedge clk);
        chk("bp_req_ready", req_ready, 0);
        chk("bp_busy", busy, 1);
        @(posedge clk);
        #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_ready_on_pop", req_ready, 1);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        drain();

        // Full buffer with simultaneous push and pop
        rsp_ready = 1'b0;
        issue(3, 1, 4, 6, acc);
        chk("full_accepted", acc, 3);
        rsp_ready = 1'b1;
        for (int j = 0; j < 6; j++) begin
            set_req((j + 4) % NV, j + 7);
            @(negedge clk);
            chk("full_count", dut.count, 2);
            chk("full_req_ready", req_ready, 1);
            @(posedge clk);
            #1;
        end
        req_valid = 1'b0;
        drain();

        // Asynchronous reset with count=2 and S1 occupied
        rsp_ready = 1'b0;
        issue(3, 7, 1, 6, acc);
        #2;
        rst_n = 1'b0;
        #1;
        sbq.delete();
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_req_ready", req_ready, 0);
        chk("arst_busy", busy, 0);
        chk("arst_result", rsp_result, 0);
        chk("arst_tag", rsp_tag, 0);
        chk("arst_flags", {rsp_exception, rsp_overflow, rsp_underflow}, 0);
        chk("arst_sticky", sticky_flags, 0);
        @(posedge clk);
        #3;
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("arst_no_stale", rsp_valid, 0);
        end
        @(posedge clk);
        #1;

`ifdef FP_ALU_RSP_STICKY_EN
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        chk("sticky_init_clr", sticky_flags, 3'b000);
        issue(1, 4, 2, 5, acc);
        drain();
        chk("sticky_ovf", sticky_flags, 3'b010);
        repeat (3) @(posedge clk);
        #1;
        chk("sticky_persist", sticky_flags, 3'b010);
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        chk("sticky_clr", sticky_flags, 3'b000);
        issue(1, 4, 3, 5, acc);
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        chk("sticky_clr_vs_write", sticky_flags, 3'b010);
        drain();
`else
        issue(3, 4, 2, 6, acc);
        drain();
        chk("sticky_off", sticky_flags, 3'b000);
        flag_clr = 1'b1;
        @(posedge clk);
        #1;
        flag_clr = 1'b0;
        chk("sticky_off_clr", sticky_flags, 3'b000);
`endif

        chk("final_sb_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
